// File: rtl/rat_recover_if.sv
// rat_recover_if: rename/RAT/committed-RAT signal bundle for rat_recover_ctrl.
// slave modport is the controller; master modport is the surrounding pipeline
// (rename stage, speculative RAT, committed RAT).
// Packing: slot k of each multi-slot bus sits at [(k+1)*W-1 : k*W].
interface rat_recover_if #(
  parameter int NUM_AREGS    = 32,
  parameter int NUM_PREGS    = 64,
  parameter int RENAME_WIDTH = 2,
  parameter int COPY_WIDTH   = 2
);
  localparam int AW = $clog2(NUM_AREGS);
  localparam int PW = $clog2(NUM_PREGS);
  logic                       flush_req;
  logic [RENAME_WIDTH-1:0]    ren_w_en;
  logic [AW*RENAME_WIDTH-1:0] ren_dst_areg;
  logic [PW*RENAME_WIDTH-1:0] ren_new_alias;
  logic [AW*COPY_WIDTH-1:0]   crat_areg;
  logic [PW*COPY_WIDTH-1:0]   crat_preg;
  logic [RENAME_WIDTH-1:0]    rat_w_en;
  logic [AW*RENAME_WIDTH-1:0] rat_dst_areg;
  logic [PW*RENAME_WIDTH-1:0] rat_new_alias;
  logic                       rename_stall;
  logic                       recover_done;
  modport master (
    output flush_req, ren_w_en, ren_dst_areg, ren_new_alias, crat_preg,
    input  crat_areg, rat_w_en, rat_dst_areg, rat_new_alias, rename_stall, recover_done
  );
  modport slave (
    input  flush_req, ren_w_en, ren_dst_areg, ren_new_alias, crat_preg,
    output crat_areg, rat_w_en, rat_dst_areg, rat_new_alias, rename_stall, recover_done
  );
endinterface

// File: rtl/rat_recover_ctrl.sv
// rat_recover_ctrl: restores the speculative RAT from the committed RAT after a flush.
// Ports: clk, rst (sync, active-high); bus (rat_recover_if.slave): flush_req,
// ren_* from rename, crat_areg/crat_preg to/from the committed RAT, rat_* to the
// speculative RAT write ports, rename_stall and the one-cycle recover_done pulse.
// Optional: define RAT_RECOVER_PERF_EN to add perf_recover_cycles (cycles spent
// copying, saturating) and perf_flush_count (accepted flushes, saturating).
module rat_recover_ctrl #(
  parameter int NUM_AREGS    = 32,
  parameter int NUM_PREGS    = 64,
  parameter int RENAME_WIDTH = 2,
  parameter int COPY_WIDTH   = 2
) (
  input logic clk,
  input logic rst,
  rat_recover_if.slave bus
`ifdef RAT_RECOVER_PERF_EN
  ,
  output logic [31:0] perf_recover_cycles,
  output logic [15:0] perf_flush_count
`endif
);
  localparam int AW = $clog2(NUM_AREGS);
  localparam int PW = $clog2(NUM_PREGS);
  localparam int NB = NUM_AREGS / COPY_WIDTH;
  localparam int CW = NB > 1 ? $clog2(NB) : 1;
  typedef enum logic {IDLE, COPY} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    done_d            = 1'b0;
    bus.crat_areg     = '0;
    bus.rat_w_en      = bus.ren_w_en;
    bus.rat_dst_areg  = bus.ren_dst_areg;
    bus.rat_new_alias = bus.ren_new_alias;
    bus.rename_stall  = 1'b0;
    if (state_q == COPY) begin
      bus.rename_stall  = 1'b1;
      bus.rat_w_en      = '0;
      bus.rat_dst_areg  = '0;
      bus.rat_new_alias = '0;
      for (int i = 0; i < COPY_WIDTH; i++) begin
        bus.crat_areg[i*AW +: AW]     = AW'(int'(cnt_q) * COPY_WIDTH + i);
        bus.rat_w_en[i]               = 1'b1;
        bus.rat_dst_areg[i*AW +: AW]  = AW'(int'(cnt_q) * COPY_WIDTH + i);
        bus.rat_new_alias[i*PW +: PW] = bus.crat_preg[i*PW +: PW];
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(NB - 1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
    // Wrong-path rename writes in the flush cycle are dropped; an in-flight
    // copy batch still lands since it is committed state anyway.
    if (bus.flush_req) begin
      if (state_q == IDLE) bus.rat_w_en = '0;
      state_d = COPY;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
    if (rst) begin
      bus.rat_w_en     = '0;
      bus.rename_stall = 1'b0;
      bus.crat_areg    = '0;
    end
  end
  assign bus.recover_done = done_q;
`ifdef RAT_RECOVER_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [15:0] perf_flush_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_flush_q  <= '0;
    end else begin
      if (state_q == COPY && !(&perf_cycles_q)) perf_cycles_q <= perf_cycles_q + 1'b1;
      if (bus.flush_req && !(&perf_flush_q)) perf_flush_q <= perf_flush_q + 1'b1;
    end
  end
  assign perf_recover_cycles = perf_cycles_q;
  assign perf_flush_count    = perf_flush_q;
`endif
endmodule

// File: tb/tb_rat_recover_ctrl.sv
// tb_rat_recover_ctrl: directed self-checking bench for rat_recover_ctrl.
module tb_rat_recover_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [5:0] rat [32];
  always #5 clk = ~clk;
  rat_recover_if #(.NUM_AREGS(32), .NUM_PREGS(64), .RENAME_WIDTH(2), .COPY_WIDTH(2)) bus ();
`ifdef RAT_RECOVER_PERF_EN
  logic [31:0] perf_recover_cycles;
  logic [15:0] perf_flush_count;
`endif
  rat_recover_ctrl #(.NUM_AREGS(32), .NUM_PREGS(64), .RENAME_WIDTH(2), .COPY_WIDTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef RAT_RECOVER_PERF_EN
    ,
    .perf_recover_cycles(perf_recover_cycles),
    .perf_flush_count(perf_flush_count)
`endif
  );
  // Committed RAT: areg a maps to preg a+32.
  assign bus.crat_preg = {1'b1, bus.crat_areg[9:5], 1'b1, bus.crat_areg[4:0]};
  // Speculative RAT written through the controller; identity on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 32; a++) rat[a] <= 6'(a);
    end else begin
      for (int k = 0; k < 2; k++)
        if (bus.rat_w_en[k]) rat[bus.rat_dst_areg[k*5 +: 5]] <= bus.rat_new_alias[k*6 +: 6];
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.flush_req = 1'b0;
    bus.ren_w_en = 2'b11;
    bus.ren_dst_areg = {5'd3, 5'd4};
    bus.ren_new_alias = {6'd1, 6'd2};
    repeat (2) step();
    #1;
    checks++; if (bus.rat_w_en !== 2'b00) begin errors++; $display("FAIL reset_w_en got=%b exp=00", bus.rat_w_en); end
    checks++; if (bus.rename_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.rename_stall); end
    checks++; if (bus.crat_areg !== 10'd0) begin errors++; $display("FAIL reset_crat_areg got=%h exp=0", bus.crat_areg); end
    checks++; if (bus.recover_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.recover_done); end
    step();
    rst = 1'b0;
    bus.ren_w_en = 2'b00;
  endtask
  task automatic test_pass_through();
    bus.ren_w_en = 2'b01;
    bus.ren_dst_areg = {5'd7, 5'd5};
    bus.ren_new_alias = {6'd9, 6'd40};
    #1;
    checks++; if (bus.rat_w_en !== 2'b01) begin errors++; $display("FAIL pass_w_en got=%b exp=01", bus.rat_w_en); end
    checks++; if (bus.rat_dst_areg !== {5'd7, 5'd5}) begin errors++; $display("FAIL pass_dst got=%h exp=%h", bus.rat_dst_areg, {5'd7, 5'd5}); end
    checks++; if (bus.rat_new_alias !== {6'd9, 6'd40}) begin errors++; $display("FAIL pass_alias got=%h exp=%h", bus.rat_new_alias, {6'd9, 6'd40}); end
    checks++; if (bus.rename_stall !== 1'b0) begin errors++; $display("FAIL pass_stall got=%b exp=0", bus.rename_stall); end
    step();
    bus.ren_w_en = 2'b00;
    #1;
    checks++; if (rat[5] !== 6'd40) begin errors++; $display("FAIL pass_rat_write got=%0d exp=40", rat[5]); end
    step();
  endtask
  task automatic test_full_recovery();
    bus.flush_req = 1'b1;
    bus.ren_w_en = 2'b11;
    bus.ren_dst_areg = {5'd3, 5'd4};
    bus.ren_new_alias = {6'd1, 6'd2};
    #1;
    checks++; if (bus.rat_w_en !== 2'b00) begin errors++; $display("FAIL flush_mask got=%b exp=00", bus.rat_w_en); end
    checks++; if (bus.rename_stall !== 1'b0) begin errors++; $display("FAIL flush_cycle_stall got=%b exp=0", bus.rename_stall); end
    step();
    bus.flush_req = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      checks++; if (bus.rename_stall !== 1'b1) begin errors++; $display("FAIL full_stall k=%0d got=%b exp=1", k, bus.rename_stall); end
      checks++; if (bus.rat_w_en !== 2'b11) begin errors++; $display("FAIL full_w_en k=%0d got=%b exp=11", k, bus.rat_w_en); end
      checks++; if (bus.rat_dst_areg !== {5'(2*k-1), 5'(2*k-2)}) begin errors++; $display("FAIL full_dst k=%0d got=%h exp=%h", k, bus.rat_dst_areg, {5'(2*k-1), 5'(2*k-2)}); end
      checks++; if (bus.crat_areg !== {5'(2*k-1), 5'(2*k-2)}) begin errors++; $display("FAIL full_crat_areg k=%0d got=%h exp=%h", k, bus.crat_areg, {5'(2*k-1), 5'(2*k-2)}); end
      checks++; if (bus.rat_new_alias !== {6'(2*k+31), 6'(2*k+30)}) begin errors++; $display("FAIL full_alias k=%0d got=%h exp=%h", k, bus.rat_new_alias, {6'(2*k+31), 6'(2*k+30)}); end
      checks++; if (bus.recover_done !== 1'b0) begin errors++; $display("FAIL full_early_done k=%0d got=%b exp=0", k, bus.recover_done); end
      step();
    end
    bus.ren_w_en = 2'b01;
    bus.ren_dst_areg = {5'd0, 5'd0};
    bus.ren_new_alias = {6'd0, 6'd32};
    #1;
    checks++; if (bus.recover_done !== 1'b1) begin errors++; $display("FAIL full_done got=%b exp=1", bus.recover_done); end
    checks++; if (bus.rename_stall !== 1'b0) begin errors++; $display("FAIL full_done_stall got=%b exp=0", bus.rename_stall); end
    checks++; if (bus.rat_w_en !== 2'b01) begin errors++; $display("FAIL full_resume_w_en got=%b exp=01", bus.rat_w_en); end
    step();
    bus.ren_w_en = 2'b00;
    #1;
    checks++; if (bus.recover_done !== 1'b0) begin errors++; $display("FAIL full_done_width got=%b exp=0", bus.recover_done); end
    for (int a = 0; a < 32; a++) begin
      checks++; if (rat[a] !== 6'(a + 32)) begin errors++; $display("FAIL full_rat a=%0d got=%0d exp=%0d", a, rat[a], a + 32); end
    end
    step();
  endtask
  task automatic test_restart();
    bus.flush_req = 1'b1;
    step();
    for (int k = 1; k <= 22; k++) begin
      int base;
      bus.flush_req = (k == 6);
      base = k <= 6 ? 2*(k-1) : 2*(k-7);
      #1;
      checks++; if (bus.rat_w_en !== 2'b11) begin errors++; $display("FAIL restart_w_en k=%0d got=%b exp=11", k, bus.rat_w_en); end
      checks++; if (bus.rat_dst_areg !== {5'(base+1), 5'(base)}) begin errors++; $display("FAIL restart_dst k=%0d got=%h exp=%h", k, bus.rat_dst_areg, {5'(base+1), 5'(base)}); end
      checks++; if (bus.recover_done !== 1'b0) begin errors++; $display("FAIL restart_early_done k=%0d got=%b exp=0", k, bus.recover_done); end
      step();
    end
    bus.flush_req = 1'b0;
    #1;
    checks++; if (bus.recover_done !== 1'b1) begin errors++; $display("FAIL restart_done got=%b exp=1", bus.recover_done); end
    step();
    #1;
    checks++; if (bus.recover_done !== 1'b0) begin errors++; $display("FAIL restart_single_done got=%b exp=0", bus.recover_done); end
    checks++; if (bus.rename_stall !== 1'b0) begin errors++; $display("FAIL restart_idle_stall got=%b exp=0", bus.rename_stall); end
    step();
  endtask
  task automatic test_back_to_back();
    bus.flush_req = 1'b1;
    step();
    for (int k = 1; k <= 32; k++) begin
      int base;
      bus.flush_req = (k == 16);
      base = k <= 16 ? 2*(k-1) : 2*(k-17);
      #1;
      checks++; if (bus.rat_dst_areg !== {5'(base+1), 5'(base)}) begin errors++; $display("FAIL b2b_dst k=%0d got=%h exp=%h", k, bus.rat_dst_areg, {5'(base+1), 5'(base)}); end
      checks++; if (bus.recover_done !== 1'b0) begin errors++; $display("FAIL b2b_last_restart_done k=%0d got=%b exp=0", k, bus.recover_done); end
      step();
    end
    bus.flush_req = 1'b1;
    bus.ren_w_en = 2'b11;
    #1;
    checks++; if (bus.recover_done !== 1'b1) begin errors++; $display("FAIL b2b_done_with_flush got=%b exp=1", bus.recover_done); end
    checks++; if (bus.rat_w_en !== 2'b00) begin errors++; $display("FAIL b2b_done_flush_mask got=%b exp=00", bus.rat_w_en); end
    step();
    bus.flush_req = 1'b0;
    bus.ren_w_en = 2'b00;
    for (int k = 1; k <= 16; k++) begin
      #1;
      checks++; if (bus.rename_stall !== 1'b1 || bus.recover_done !== 1'b0) begin errors++; $display("FAIL b2b_third_pass k=%0d stall=%b done=%b exp stall=1 done=0", k, bus.rename_stall, bus.recover_done); end
      step();
    end
    #1;
    checks++; if (bus.recover_done !== 1'b1) begin errors++; $display("FAIL b2b_third_done got=%b exp=1", bus.recover_done); end
    step();
  endtask
  task automatic test_reset_mid_copy();
    bus.flush_req = 1'b1;
    step();
    bus.flush_req = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    bus.ren_w_en = 2'b11;
    #1;
    checks++; if (bus.rat_w_en !== 2'b00) begin errors++; $display("FAIL rstmid_w_en got=%b exp=00", bus.rat_w_en); end
    checks++; if (bus.rename_stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got=%b exp=0", bus.rename_stall); end
    checks++; if (bus.crat_areg !== 10'd0) begin errors++; $display("FAIL rstmid_crat_areg got=%h exp=0", bus.crat_areg); end
    step();
    rst = 1'b0;
    bus.ren_w_en = 2'b00;
    for (int k = 5; k <= 7; k++) begin
      #1;
      checks++; if (bus.rename_stall !== 1'b0) begin errors++; $display("FAIL rstmid_after_stall k=%0d got=%b exp=0", k, bus.rename_stall); end
      checks++; if (bus.rat_w_en !== 2'b00) begin errors++; $display("FAIL rstmid_after_w_en k=%0d got=%b exp=00", k, bus.rat_w_en); end
      checks++; if (bus.recover_done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done k=%0d got=%b exp=0", k, bus.recover_done); end
      step();
    end
    for (int a = 0; a < 32; a++) begin
      checks++; if (rat[a] !== 6'(a)) begin errors++; $display("FAIL rstmid_rat a=%0d got=%0d exp=%0d", a, rat[a], a); end
    end
  endtask
`ifdef RAT_RECOVER_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (perf_recover_cycles !== 32'd0 || perf_flush_count !== 16'd0) begin errors++; $display("FAIL perf_reset cycles=%0d flushes=%0d exp 0 0", perf_recover_cycles, perf_flush_count); end
    for (int p = 0; p < 2; p++) begin
      bus.flush_req = 1'b1;
      step();
      bus.flush_req = 1'b0;
      repeat (18) step();
    end
    #1;
    checks++; if (perf_recover_cycles !== 32'd32) begin errors++; $display("FAIL perf_cycles got=%0d exp=32", perf_recover_cycles); end
    checks++; if (perf_flush_count !== 16'd2) begin errors++; $display("FAIL perf_flushes got=%0d exp=2", perf_flush_count); end
  endtask
`endif
  initial begin
    test_reset();
    test_pass_through();
    test_full_recovery();
    test_restart();
    test_back_to_back();
    test_reset_mid_copy();
`ifdef RAT_RECOVER_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rat_recover_ctrl.md
Name: rat_recover_ctrl

Overview:
- Sequences speculative RAT restoration after a pipeline flush.
- Owns the RAT write ports. In normal operation it forwards rename-stage writes unchanged.
- On a flush it stalls rename and copies the committed (retirement) RAT into the speculative RAT, COPY_WIDTH entries per cycle, then pulses done.
- Sits between rename logic and the RAT; reads the committed RAT through its combinational read ports.

Parameters:
NUM_AREGS, 32, architectural register count (power of 2)
NUM_PREGS, 64, physical register count (power of 2)
RENAME_WIDTH, 2, RAT write ports
COPY_WIDTH, 2, entries restored per cycle; must be <= RENAME_WIDTH and divide NUM_AREGS
AW = clog2(NUM_AREGS), PW = clog2(NUM_PREGS) (localparams)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush_req  in  1  start/restart recovery
ren_w_en  in  RENAME_WIDTH  rename write enables
ren_dst_areg  in  AW*RENAME_WIDTH  rename dest aregs, slot k at [(k+1)*AW-1 : k*AW]
ren_new_alias  in  PW*RENAME_WIDTH  rename new pregs, same packing
crat_areg  out  AW*COPY_WIDTH  committed-RAT read addresses
crat_preg  in  PW*COPY_WIDTH  committed-RAT read data, same-cycle
rat_w_en  out  RENAME_WIDTH  to RAT w_en
rat_dst_areg  out  AW*RENAME_WIDTH  to RAT dst_areg
rat_new_alias  out  PW*RENAME_WIDTH  to RAT new_alias
rename_stall  out  1  rename must hold; its writes are dropped
recover_done  out  1  one-cycle pulse, recovery complete

Behaviour:
- FSM states: IDLE, COPY. Batch counter cnt, width clog2(NUM_AREGS/COPY_WIDTH); next base areg = cnt*COPY_WIDTH.
- Reset:
  - state=IDLE, cnt=0, recover_done=0.
  - While rst is high: rat_w_en=0, rename_stall=0, crat_areg=0.
- IDLE:
  - rat_* = ren_* pass-through (combinational). crat_areg=0. rename_stall=0.
  - If flush_req=1: rat_w_en forced to 0 this cycle (wrong-path writes dropped). Next state COPY, cnt=0.
- COPY:
  - rename_stall=1.
  - Slot i<COPY_WIDTH: crat_areg[i]=cnt*COPY_WIDTH+i; rat_w_en[i]=1; rat_dst_areg[i]=same areg; rat_new_alias[i]=crat_preg[i].
  - Slots >= COPY_WIDTH: w_en=0.
  - ren_* ignored.
  - cnt increments each cycle. On the last batch (cnt = NUM_AREGS/COPY_WIDTH-1), next state is IDLE and recover_done is registered to 1 for the following cycle.
- Latency: flush_req sampled at cycle T. Copy writes occur in cycles T+1..T+N with N=NUM_AREGS/COPY_WIDTH. recover_done=1 and state=IDLE at T+N+1. Rename writes pass through again at T+N+1.
- flush_req during COPY: cnt restarts at 0 next cycle, the current batch's write still occurs, and recover_done is not pulsed for the aborted pass.
- flush_req on the last COPY cycle: restart wins; no done pulse.
- flush_req in the done cycle (IDLE): normal IDLE flush handling; recover_done still pulses that cycle.
- rst mid-COPY: immediate return to IDLE next edge, no done pulse. The RAT's own reset restores identity mapping.
- No combinational path from crat_preg to rename_stall or recover_done.

Optional Feature:
- Macro: RAT_RECOVER_PERF_EN.
- When defined:
  - Adds output perf_recover_cycles (32 bits), counting cycles in COPY.
  - Saturates at 0xFFFFFFFF; cleared only by rst.
  - Adds output perf_flush_count (16 bits), counting accepted flush_req edges.
  - Saturates at 0xFFFF; cleared only by rst.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Setup for all scenarios: NUM_AREGS=32, COPY_WIDTH=2 unless stated.
- Pass-through: rst low, IDLE, ren_w_en=2'b01, ren_dst_areg slot0=5, ren_new_alias slot0=40 -> same cycle rat_w_en=01, dst=5, alias=40, rename_stall=0.
- Full recovery: committed RAT model areg a -> preg a+32; pulse flush_req at T -> 16 cycles of writes (areg pairs 0/1 ... 30/31) with aliases a+32, stall high T+1..T+16, recover_done=1 only at T+17; RAT then reads a+32 for all a.
- Flush-cycle masking: flush_req=1 together with ren_w_en=11 in IDLE -> rat_w_en=00 that cycle.
- Restart: second flush_req at T+6 -> cnt back to 0 at T+7, writes continue to T+22, single recover_done at T+23.
- Reset mid-copy: rst at T+4 -> rat_w_en=0, rename_stall=0 from T+5, no recover_done; the RAT holds identity.
- PERF (macro defined): two full recoveries -> perf_recover_cycles=32, perf_flush_count=2.
